// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the FIFO write-port arbiter, its requesters and the async FIFO write side.
// Latency: none, this is wiring only.
// Backpressure: wfull from the FIFO throttles the arbiter, which withholds gnt from requesters.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  // Arbiter side: consumes requests and the full flag, drives grants and the FIFO write port.
  modport master (input req, req_data, wfull, output gnt, winc, wdata, busy);
  // Environment side: requesters plus the FIFO.
  modport slave  (output req, req_data, wfull, input gnt, winc, wdata, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters, with optional burst lock.
// Latency: word granted at edge N is on winc/wdata after edge N; 1 word/cycle while wfull=0.
// Backpressure: one-word holding register; while it is full and wfull=1, gnt is 0 and all state holds.
// Build option: define FIFO_WARB_BURST_EN to enable burst locking (up to MAX_BURST words per owner).
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              wclk,
  input  logic              wrst,
  fifo_wr_arbiter_if.master bus
);

  localparam int          IW     = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             hv_q, hv_d;
  logic [DSIZE-1:0] hd_q, hd_d;

  logic             accept_ok;
  logic             drain;
  logic             grant_en;
  logic             found;
  logic [IW-1:0]    pick;
  logic [IW:0]      idx;
  logic [IW:0]      rr_nxt;
  logic             grant;
  logic [IW-1:0]    gsel;
  logic [NREQ-1:0]  gnt_c;

`ifdef FIFO_WARB_BURST_EN
  localparam int          CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_BURST_W = CW'(MAX_BURST);

  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cont;
`endif

  // The holding register can take a new word if it is empty or is being written this cycle.
  assign accept_ok = ~hv_q | ~bus.wfull;
  assign drain     = hv_q & ~bus.wfull;
  assign grant_en  = accept_ok & ~wrst;

  // Round-robin search: first requester at or after rr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + (IW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && bus.req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

`ifdef FIFO_WARB_BURST_EN
  // The current owner keeps the port while it still requests and its burst budget remains.
  always_comb begin
    cont = (state_q == ST_LOCK) && bus.req[owner_q] && (cnt_q < MAX_BURST_W);
  end
`endif

  // Next-state: grant selection, pointer/burst update and holding-register load/drain.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hv_d    = hv_q;
    hd_d    = hd_q;
    grant   = 1'b0;
    gsel    = '0;
    gnt_c   = '0;
    rr_nxt  = '0;
`ifdef FIFO_WARB_BURST_EN
    owner_d = owner_q;
    cnt_d   = cnt_q;
`endif

    if (drain) hv_d = 1'b0;

    if (grant_en) begin
`ifdef FIFO_WARB_BURST_EN
      if (cont) begin
        grant = 1'b1;
        gsel  = owner_q;
        cnt_d = cnt_q + 1'b1;
      end else
`endif
      if (found) begin
        grant  = 1'b1;
        gsel   = pick;
        rr_nxt = {1'b0, pick} + 1'b1;
        if (rr_nxt == NREQ_W) rr_nxt = '0;
        rr_d   = rr_nxt[IW-1:0];
`ifdef FIFO_WARB_BURST_EN
        if (MAX_BURST > 1) begin
          state_d = ST_LOCK;
          owner_d = pick;
          cnt_d   = CW'(1);
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end

    // A grant in the same cycle as a drain refills the register, so hv stays 1.
    if (grant) begin
      gnt_c[gsel] = 1'b1;
      hv_d        = 1'b1;
      hd_d        = bus.req_data[gsel*DSIZE +: DSIZE];
    end
  end

  // State registers with synchronous reset; a held word is discarded on reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      hv_q    <= 1'b0;
      hd_q    <= '0;
`ifdef FIFO_WARB_BURST_EN
      owner_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hv_q    <= hv_d;
      hd_q    <= hd_d;
`ifdef FIFO_WARB_BURST_EN
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.winc  = hv_q;
  assign bus.wdata = hd_q;
`ifdef FIFO_WARB_BURST_EN
  assign bus.busy  = (state_q == ST_LOCK);
`else
  assign bus.busy  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4).
// Expectations follow whether FIFO_WARB_BURST_EN is defined for the build.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_wr_arbiter;

  logic wclk;
  logic wrst;
  int   vecs;
  int   miscmp;
  logic [7:0] wd [4];
  logic [7:0] wlog [$];

  fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(4)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // Models the FIFO write port: records every word actually written.
  always @(posedge wclk) begin
    if (bus.winc === 1'b1 && bus.wfull === 1'b0) wlog.push_back(bus.wdata);
  end

  task automatic apply(input logic [3:0] r, input logic wf);
    bus.req   = r;
    bus.wfull = wf;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = wd[i];
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst = 1'b1;
    for (int i = 0; i < 4; i++) wd[i] = 8'(i * 16);
    apply(4'b0000, 1'b0);
    @(negedge wclk);
    wrst = 1'b0;
    wlog.delete();
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    for (int i = 0; i < 4; i++) wd[i] = 8'(i * 16);
    apply(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      #1;
      vecs++; if (bus.gnt !== 4'b0000) begin miscmp++; $display("FAIL reset gnt c%0d: got %b want 0000", c, bus.gnt); end
      vecs++; if (bus.winc !== 1'b0) begin miscmp++; $display("FAIL reset winc c%0d: got %b want 0", c, bus.winc); end
      vecs++; if (bus.wdata !== 8'h00) begin miscmp++; $display("FAIL reset wdata c%0d: got %h want 00", c, bus.wdata); end
      vecs++; if (bus.busy !== 1'b0) begin miscmp++; $display("FAIL reset busy c%0d: got %b want 0", c, bus.busy); end
      vecs++; if (dut.rr_q !== 2'd0) begin miscmp++; $display("FAIL reset rr c%0d: got %0d want 0", c, dut.rr_q); end
    end
    @(negedge wclk);
    wrst = 1'b0;
    #1;
    vecs++; if (bus.gnt !== 4'b0001) begin miscmp++; $display("FAIL reset first grant: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_burst_rr();
    logic [3:0] eg;
    logic [7:0] prev;
    logic       eb;
    int         g;
    do_reset();
    prev = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge wclk);
`ifdef FIFO_WARB_BURST_EN
      g  = ((k / 4) % 2) * 2;
      eb = (k > 0);
`else
      g  = (k % 2) * 2;
      eb = 1'b0;
`endif
      eg = 4'(1 << g);
      apply(4'b0101, 1'b0);
      #1;
      vecs++; if (bus.gnt !== eg) begin miscmp++; $display("FAIL burst gnt k%0d: got %b want %b", k, bus.gnt, eg); end
      vecs++; if (bus.busy !== eb) begin miscmp++; $display("FAIL burst busy k%0d: got %b want %b", k, bus.busy, eb); end
      if (k > 0) begin
        vecs++; if (bus.winc !== 1'b1) begin miscmp++; $display("FAIL burst winc k%0d: got %b want 1", k, bus.winc); end
        vecs++; if (bus.wdata !== prev) begin miscmp++; $display("FAIL burst wdata k%0d: got %h want %h", k, bus.wdata, prev); end
      end
      prev  = wd[g];
      wd[g] = wd[g] + 8'd1;
    end
  endtask

  task automatic test_early_release();
    logic [3:0] rq [4];
    logic [3:0] eg [4];
    logic       eb [4];
    logic [7:0] prev;
    int         g;
    do_reset();
    rq[0] = 4'b1010; rq[1] = 4'b1010; rq[2] = 4'b1000; rq[3] = 4'b1000;
`ifdef FIFO_WARB_BURST_EN
    eg[0] = 4'b0010; eg[1] = 4'b0010; eg[2] = 4'b1000; eg[3] = 4'b1000;
    eb[0] = 1'b0;    eb[1] = 1'b1;    eb[2] = 1'b1;    eb[3] = 1'b1;
`else
    eg[0] = 4'b0010; eg[1] = 4'b1000; eg[2] = 4'b1000; eg[3] = 4'b1000;
    eb[0] = 1'b0;    eb[1] = 1'b0;    eb[2] = 1'b0;    eb[3] = 1'b0;
`endif
    prev = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      apply(rq[k], 1'b0);
      #1;
      vecs++; if (bus.gnt !== eg[k]) begin miscmp++; $display("FAIL release gnt k%0d: got %b want %b", k, bus.gnt, eg[k]); end
      vecs++; if (bus.busy !== eb[k]) begin miscmp++; $display("FAIL release busy k%0d: got %b want %b", k, bus.busy, eb[k]); end
      if (k > 0) begin
        vecs++; if (bus.winc !== 1'b1) begin miscmp++; $display("FAIL release winc k%0d: got %b want 1", k, bus.winc); end
        vecs++; if (bus.wdata !== prev) begin miscmp++; $display("FAIL release wdata k%0d: got %h want %h", k, bus.wdata, prev); end
      end
      g     = (eg[k] == 4'b0010) ? 1 : 3;
      prev  = wd[g];
      wd[g] = wd[g] + 8'd1;
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    wd[0] = 8'hA5;
    wd[1] = 8'h3C;
    @(negedge wclk);
    apply(4'b0001, 1'b0);
    #1;
    vecs++; if (bus.gnt !== 4'b0001) begin miscmp++; $display("FAIL stall load gnt: got %b want 0001", bus.gnt); end
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      apply(4'b0010, 1'b1);
      #1;
      vecs++; if (bus.gnt !== 4'b0000) begin miscmp++; $display("FAIL stall gnt c%0d: got %b want 0000", c, bus.gnt); end
      vecs++; if (bus.winc !== 1'b1) begin miscmp++; $display("FAIL stall winc c%0d: got %b want 1", c, bus.winc); end
      vecs++; if (bus.wdata !== 8'hA5) begin miscmp++; $display("FAIL stall wdata c%0d: got %h want a5", c, bus.wdata); end
    end
    @(negedge wclk);
    apply(4'b0010, 1'b0);
    #1;
    vecs++; if (bus.gnt !== 4'b0010) begin miscmp++; $display("FAIL stall release gnt: got %b want 0010", bus.gnt); end
    vecs++; if (bus.wdata !== 8'hA5) begin miscmp++; $display("FAIL stall release wdata: got %h want a5", bus.wdata); end
    @(negedge wclk);
    apply(4'b0000, 1'b0);
    #1;
    vecs++; if (bus.winc !== 1'b1) begin miscmp++; $display("FAIL stall next winc: got %b want 1", bus.winc); end
    vecs++; if (bus.wdata !== 8'h3C) begin miscmp++; $display("FAIL stall next wdata: got %h want 3c", bus.wdata); end
    @(negedge wclk);
    #1;
    vecs++; if (bus.winc !== 1'b0) begin miscmp++; $display("FAIL stall empty winc: got %b want 0", bus.winc); end
    vecs++; if (wlog.size() !== 2) begin miscmp++; $display("FAIL stall write count: got %0d want 2", wlog.size()); end
    if (wlog.size() == 2) begin
      vecs++; if (wlog[0] !== 8'hA5) begin miscmp++; $display("FAIL stall write0: got %h want a5", wlog[0]); end
      vecs++; if (wlog[1] !== 8'h3C) begin miscmp++; $display("FAIL stall write1: got %h want 3c", wlog[1]); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [4];
    logic [3:0] eg [4];
    logic [1:0] er [4];
    do_reset();
    rq[0] = 4'b1000; rq[1] = 4'b1001; rq[2] = 4'b1001; rq[3] = 4'b1001;
`ifdef FIFO_WARB_BURST_EN
    eg[0] = 4'b1000; eg[1] = 4'b1000; eg[2] = 4'b1000; eg[3] = 4'b1000;
    er[0] = 2'd0;    er[1] = 2'd0;    er[2] = 2'd0;    er[3] = 2'd0;
`else
    eg[0] = 4'b1000; eg[1] = 4'b0001; eg[2] = 4'b1000; eg[3] = 4'b0001;
    er[0] = 2'd0;    er[1] = 2'd0;    er[2] = 2'd1;    er[3] = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      apply(rq[k], 1'b0);
      #1;
      vecs++; if (bus.gnt !== eg[k]) begin miscmp++; $display("FAIL wrap gnt k%0d: got %b want %b", k, bus.gnt, eg[k]); end
      vecs++; if (dut.rr_q !== er[k]) begin miscmp++; $display("FAIL wrap rr k%0d: got %0d want %0d", k, dut.rr_q, er[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic eb;
    do_reset();
    wd[0] = 8'h5A;
    @(negedge wclk);
    apply(4'b0001, 1'b0);
    #1;
    vecs++; if (bus.gnt !== 4'b0001) begin miscmp++; $display("FAIL midrst grant: got %b want 0001", bus.gnt); end
    @(negedge wclk);
    wd[0] = 8'h5B;
    wrst  = 1'b1;
    apply(4'b0001, 1'b1);
    #1;
`ifdef FIFO_WARB_BURST_EN
    eb = 1'b1;
`else
    eb = 1'b0;
`endif
    vecs++; if (bus.gnt !== 4'b0000) begin miscmp++; $display("FAIL midrst gnt in reset: got %b want 0000", bus.gnt); end
    vecs++; if (bus.winc !== 1'b1) begin miscmp++; $display("FAIL midrst held winc: got %b want 1", bus.winc); end
    vecs++; if (bus.wdata !== 8'h5A) begin miscmp++; $display("FAIL midrst held wdata: got %h want 5a", bus.wdata); end
    vecs++; if (bus.busy !== eb) begin miscmp++; $display("FAIL midrst busy before: got %b want %b", bus.busy, eb); end
    @(negedge wclk);
    wrst = 1'b0;
    apply(4'b0000, 1'b0);
    #1;
    vecs++; if (bus.winc !== 1'b0) begin miscmp++; $display("FAIL midrst winc after: got %b want 0", bus.winc); end
    vecs++; if (bus.busy !== 1'b0) begin miscmp++; $display("FAIL midrst busy after: got %b want 0", bus.busy); end
    vecs++; if (dut.rr_q !== 2'd0) begin miscmp++; $display("FAIL midrst rr after: got %0d want 0", dut.rr_q); end
    @(negedge wclk);
    #1;
    vecs++; if (wlog.size() !== 0) begin miscmp++; $display("FAIL midrst writes: got %0d want 0", wlog.size()); end
  endtask

  initial begin
    vecs   = 0;
    miscmp = 0;
    test_reset();
    test_burst_rr();
    test_early_release();
    test_full_stall();
    test_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the team's asynchronous FIFO among NREQ requesters in the write clock domain. Selects a requester round-robin, optionally locks onto it for a burst of up to MAX_BURST words, and drives the FIFO's `winc`/`wdata` from a one-word holding register. Honours the FIFO's registered `wfull` flag, so no word is ever lost or duplicated while the FIFO is full.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DSIZE, 8: data word width; matches the FIFO memory width.
- MAX_BURST, 4: maximum consecutive words granted to one owner, 1..16.

- wclk  in  1  write-domain clock; all logic on its rising edge.
- wrst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request; the word on the requester's slice is valid while high.
- req_data  in  NREQ*DSIZE  requester i's word is at bits [i*DSIZE +: DSIZE].
- gnt  out  NREQ  one-hot or zero; `gnt[i]`=1 means requester i's word is taken at this edge.
- wfull  in  1  FIFO full flag, in the wclk domain.
- winc  out  1  FIFO write enable; equals holding-register valid.
- wdata  out  DSIZE  FIFO write data; the holding-register contents.
- busy  out  1  high while in LOCK.

## Operation
- **Holding register:** `hv` (valid) and `hd` (data). `winc`=`hv` and `wdata`=`hd`.
  - Drain: `hv & ~wfull`. The FIFO itself ignores `winc` while `wfull`=1.
  - `accept_ok` = `~hv | ~wfull`.
- **Grant:** at most one per cycle, only when `accept_ok`=1 and `wrst`=0. On a grant to i:
  - `hd` <= word i;
  - `hv` <= 1;
  - if there is no grant but a drain occurs, `hv` <= 0.
- **FSM states:**
  - IDLE: no owner.
  - LOCK: registers `owner` (clog2 NREQ bits) and `cnt` (1..MAX_BURST).
- **Round-robin pointer `rr`:** reset value 0. The pick is the first i with `req[i]`, searched `rr`, `rr+1`, … modulo NREQ.
- **Each cycle with `accept_ok`=1:**
  - **Continue:** if LOCK, `req[owner]`=1 and `cnt`<MAX_BURST, grant `owner` and `cnt`++. Stay in LOCK.
  - **Otherwise, any `req` set:** grant the RR pick p (p may equal the old owner if no one else requests).
    - `rr` <= (p+1) mod NREQ.
    - If MAX_BURST>1: go to LOCK with `owner`=p, `cnt`=1. Otherwise go to IDLE.
  - **Otherwise:** go to IDLE.
- **When `accept_ok`=0:** no grant. FSM, `rr`, `cnt` and the holding register are all held.
- **LOCK exit:** dropping `req[owner]` ends the burst. That cycle re-arbitrates with no bubble.
- **Requester rules:** requesters must hold `req` and the data stable until granted. After a grant, the next word (if `req` stays high) is presented in the following cycle.

## Timing
- **Reset values** (one `wclk` edge with `wrst`=1): `hv`=0, `winc`=0, `wdata`=0, IDLE, `rr`=0, `cnt`=0, `owner`=0, `busy`=0. `gnt` is forced to 0 while `wrst`=1.
- **`gnt` is combinational** from `req`, `wfull`, `hv`, state and `rr`. There is no combinational path from `req_data`.
- **Latency:** word granted at edge N appears on `winc`/`wdata` after edge N. It is written to the FIFO at the first edge ≥ N+1 where `wfull`=0.
- **Throughput:** 1 word/cycle sustained while `wfull`=0.
- **Full, grant and drain in the same cycle:** `hv` stays 1. No duplicate write, no dropped word.
- **Reset mid-burst:** the held word is discarded (`hv`=0). Requesters must re-present.
- **Wrap-around:** `rr` wraps NREQ-1 -> 0.

## Configuration
- `FIFO_WARB_BURST_EN` defined:
  - burst locking per Operation;
  - `busy` reflects LOCK.
- Undefined:
  - LOCK never entered, so the arbiter is pure per-word round-robin, exactly as if MAX_BURST=1;
  - `cnt`/`owner` are not built;
  - `busy` is tied to 0;
  - MAX_BURST is ignored.

## Test plan
- **Reset:** hold `wrst`=1 for 3 cycles with `req`=4'b1111 -> `gnt`=0, `winc`=0, `wdata`=0 throughout. The first grant after release goes to requester 0.
- **Burst + round-robin** (burst EN, MAX_BURST=4, `wfull`=0, `req`=4'b0101 held):
  - `gnt` sequence is 0,0,0,0,2,2,2,2,0…;
  - `winc` is continuously 1 from the cycle after the first grant;
  - `wdata` follows the granted words one cycle later.
- **Early release:** owner 1 drops `req` after 2 words while `req[3]`=1 -> requester 3 is granted in the very next cycle with no idle cycle. `busy` stays 1.
- **Full stall:** holding word 0xA5, force `wfull`=1 for 5 cycles -> `winc`=1, `wdata`=0xA5, `gnt`=0 throughout. When `wfull`=0, 0xA5 is written exactly once and the next grant occurs in the same cycle.
- **Wrap:** NREQ=4, burst off, `req`=4'b1000 then 4'b1001 -> grants 3 then 0; `rr` wraps to 0.
- **Reset mid-burst:** assert `wrst` during LOCK with `hv`=1 -> next cycle `winc`=0, `busy`=0, `rr`=0; the pending word is not written.
